// File: rtl/data_memory_responder_pkg.sv
// Shared constants for the data memory responder: RV64 load/store funct3
// encodings, FSM states and default geometry.
package data_memory_responder_pkg;

    localparam int DEFAULT_DEPTH   = 64;
    localparam int DEFAULT_LATENCY = 2;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/data_memory_responder_if.sv
// MEM-stage request/response bus between the pipeline (master) and the
// data memory responder (slave).
interface data_memory_responder_if;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_error;
    logic        stall;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error, stall
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error, stall
    );
endinterface

// File: rtl/mem_align_unit.sv
// Combinational access decode: size, fault detection, store byte-lane mask
// and load sign/zero extension of the little-endian raw doubleword.
module mem_align_unit
    import data_memory_responder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic        write,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] load_raw,
    output logic        error,
    output logic [7:0]  lane_mask,
    output logic [63:0] load_data
);

    logic [3:0] size;
    logic       misaligned;
    logic       out_of_range;
    logic       illegal;

    always_comb begin
        size         = 4'd1 << funct3[1:0];
        misaligned   = (addr[2:0] & (size[2:0] - 3'd1)) != 3'd0;
        // 65-bit sum so addresses near 2^64 cannot wrap into range
        out_of_range = ({1'b0, addr} + 65'(size)) > 65'(DEPTH);
        illegal      = write ? funct3[2] : (funct3 == 3'b111);
        error        = misaligned | out_of_range | illegal;

        lane_mask = 8'h00;
        if (write && !error) begin
            case (funct3)
                F3_SB:   lane_mask = 8'h01;
                F3_SH:   lane_mask = 8'h03;
                F3_SW:   lane_mask = 8'h0F;
                F3_SD:   lane_mask = 8'hFF;
                default: lane_mask = 8'h00;
            endcase
        end

        load_data = 64'd0;
        if (!write && !error) begin
            case (funct3)
                F3_LB:   load_data = {{56{load_raw[7]}},  load_raw[7:0]};
                F3_LH:   load_data = {{48{load_raw[15]}}, load_raw[15:0]};
                F3_LW:   load_data = {{32{load_raw[31]}}, load_raw[31:0]};
                F3_LD:   load_data = load_raw;
                F3_LBU:  load_data = {56'd0, load_raw[7:0]};
                F3_LHU:  load_data = {48'd0, load_raw[15:0]};
                F3_LWU:  load_data = {32'd0, load_raw[31:0]};
                default: load_data = 64'd0;
            endcase
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Byte-addressed data memory with a fixed-latency single-outstanding
// request/response protocol and a debug view of the first four doublewords.
module data_memory_responder
    import data_memory_responder_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic                        clk,
    input  logic                        reset,
    data_memory_responder_if.slave      bus,
    output logic [63:0]                 element1,
    output logic [63:0]                 element2,
    output logic [63:0]                 element3,
    output logic [63:0]                 element4
);

    localparam int AW = $clog2(DEPTH);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        enter_resp;

    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;

    logic [7:0]  mem_q [DEPTH];
    logic [7:0]  mem_d [DEPTH];

    logic        resp_valid_q, resp_valid_d;
    logic        resp_error_q, resp_error_d;
    logic [63:0] resp_rdata_q, resp_rdata_d;

    logic        cur_write;
    logic [2:0]  cur_funct3;
    logic [63:0] cur_addr;
    logic [63:0] cur_wdata;
    logic [AW-1:0] base_idx;
    logic [63:0] load_raw;
    logic        acc_error;
    logic [7:0]  lane_mask;
    logic [63:0] load_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    end

    always_comb begin
        bus.req_ready  = (state_q == ST_IDLE);
        bus.stall      = bus.req_valid | (state_q != ST_IDLE);
        bus.resp_valid = resp_valid_q;
        bus.resp_error = resp_error_q;
        bus.resp_rdata = resp_rdata_q;
    end

    // With LATENCY=1 the access completes on the accepting edge, so the live
    // request fields are used in IDLE and the latched copy afterwards.
    always_comb begin
        cur_write  = (state_q == ST_IDLE) ? bus.req_write  : write_q;
        cur_funct3 = (state_q == ST_IDLE) ? bus.req_funct3 : funct3_q;
        cur_addr   = (state_q == ST_IDLE) ? bus.req_addr   : addr_q;
        cur_wdata  = (state_q == ST_IDLE) ? bus.req_wdata  : wdata_q;
        base_idx   = cur_addr[AW-1:0];
    end

    always_comb begin
        load_raw = 64'd0;
        for (int i = 0; i < 8; i++) begin
            load_raw[8*i +: 8] = mem_q[base_idx + AW'(i)];
        end
    end

    mem_align_unit #(.DEPTH(DEPTH)) u_align (
        .write     (cur_write),
        .funct3    (cur_funct3),
        .addr      (cur_addr),
        .load_raw  (load_raw),
        .error     (acc_error),
        .lane_mask (lane_mask),
        .load_data (load_data)
    );

    always_comb begin
        write_d  = write_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        if (state_q == ST_IDLE && bus.req_valid) begin
            write_d  = bus.req_write;
            funct3_d = bus.req_funct3;
            addr_d   = bus.req_addr;
            wdata_d  = bus.req_wdata;
        end

        mem_d        = mem_q;
        resp_valid_d = enter_resp;
        resp_error_d = 1'b0;
        resp_rdata_d = 64'd0;
        if (enter_resp) begin
            resp_error_d = acc_error;
            resp_rdata_d = load_data;
            for (int i = 0; i < 8; i++) begin
                if (lane_mask[i]) mem_d[base_idx + AW'(i)] = cur_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        write_q  <= write_d;
        funct3_q <= funct3_d;
        addr_q   <= addr_d;
        wdata_q  <= wdata_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'd0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= 64'd0;
        end else begin
            mem_q        <= mem_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    always_comb begin
        element1 = 64'd0;
        element2 = 64'd0;
        element3 = 64'd0;
        element4 = 64'd0;
        for (int i = 0; i < 8; i++) begin
            if (i < DEPTH)      element1[8*i +: 8] = mem_q[AW'(i)];
            if (8 + i < DEPTH)  element2[8*i +: 8] = mem_q[AW'(8 + i)];
            if (16 + i < DEPTH) element3[8*i +: 8] = mem_q[AW'(16 + i)];
            if (24 + i < DEPTH) element4[8*i +: 8] = mem_q[AW'(24 + i)];
        end
    end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 Parameter DEPTH, default 64, byte capacity of the memory array; power of two, at least 8.
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to response; range 1..15.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port req_valid  input  1  MEM-stage access request present.
REQ-006 Port req_write  input  1  1 = store, 0 = load.
REQ-007 Port req_funct3  input  3  RV64 load/store funct3 (size and sign).
REQ-008 Port req_addr  input  64  byte address.
REQ-009 Port req_wdata  input  64  store data; low bytes used per size.
REQ-010 Port req_ready  output  1  responder can accept a request this cycle.
REQ-011 Port resp_valid  output  1  one-cycle pulse; response fields valid.
REQ-012 Port resp_rdata  output  64  load result, extended per funct3; 0 for stores and errors.
REQ-013 Port resp_error  output  1  access faulted; qualified by resp_valid.
REQ-014 Port stall  output  1  pipeline hold request while an access is outstanding.
REQ-015 Ports element1..element4  output  64 each  debug view of doublewords at byte addresses 0, 8, 16 and 24.

Function
REQ-016 States: IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-017 Acceptance occurs on a rising edge with req_valid=1 in IDLE; request fields are latched at that edge.
REQ-018 Acceptance moves to WAIT with countdown = LATENCY-1, or directly to RESP when LATENCY=1.
REQ-019 WAIT decrements each cycle and moves to RESP when the count reaches 0.
REQ-020 RESP lasts exactly one cycle with resp_valid=1, then returns to IDLE.
REQ-021 resp_valid is therefore high exactly LATENCY cycles after the accepting edge, and a new request is accepted no earlier than LATENCY+1 cycles after the previous one.
REQ-022 stall = req_valid OR (state != IDLE), combinational.
REQ-023 Loads are little-endian and use funct3 000 lb, 001 lh, 010 lw, 011 ld (sign-extended) and 100 lbu, 101 lhu, 110 lwu (zero-extended).
REQ-024 Stores use funct3 000 sb, 001 sh, 010 sw, 011 sd and write only the addressed bytes.
REQ-025 Store bytes are committed on the edge that enters RESP; the array is unchanged before that edge.
REQ-026 Load data is sampled from the array on the edge entering RESP.
REQ-027 Error conditions:
  - address not aligned to access size;
  - addr + size > DEPTH, evaluated on the full 64-bit address;
  - illegal funct3 (111 for loads; 1xx for stores).
REQ-028 On error: no array write, resp_error=1, resp_rdata=0.
REQ-029 req_valid dropping while in WAIT has no effect on the latched access.

Reset
REQ-030 Reset forces IDLE, countdown 0, resp_valid 0, resp_error 0, resp_rdata 0 and all array bytes 0.
REQ-031 Reset asserted mid-access discards the in-flight request: no write, no response pulse.
REQ-032 req_ready is high in the first cycle after reset deasserts.

Structure
REQ-033 A shared package holds funct3 load/store constants, the state enumeration and the default DEPTH and LATENCY values.
REQ-034 One sub-module, mem_align_unit, is natural: combinational size decode, alignment/range check, byte-lane write mask and load extension.

Verification
REQ-035 Reset, then sd 0x1122334455667788 to addr 8, LATENCY=2:
  - resp_valid exactly 2 cycles after acceptance, resp_error 0;
  - element2 = 0x1122334455667788.
REQ-036 After REQ-035:
  - lb addr 15 -> resp_rdata 0x0000000000000011;
  - lw addr 8 -> 0x0000000055667788;
  - lh addr 14 -> 0x0000000000001122.
REQ-037 sb 0x80 to addr 0:
  - lb addr 0 -> 0xFFFFFFFFFFFFFF80;
  - lbu addr 0 -> 0x0000000000000080.
REQ-038 Error cases:
  - ld addr 4 -> resp_error 1, resp_rdata 0;
  - sd addr 64 with DEPTH=64 -> resp_error 1, array unchanged.
REQ-039 req_valid held high through back-to-back requests:
  - req_ready low and stall high during WAIT/RESP;
  - second request accepted on the cycle after the first resp_valid pulse.
REQ-040 Reset asserted during WAIT of sd 0xFF..FF to addr 0:
  - no resp_valid pulse;
  - element1 = 0 afterwards.
